pe_rs_multi: RTL

- Row-stationary processing element, next generation of the int8 PE.
- Holds NUM_FILT filter rows and one ifmap row in internal register scratchpads.
- Computes a strided 1-D convolution of every filter against the ifmap row, one MAC per cycle.
- Optionally adds an incoming psum row from the neighbouring PE, then streams results out over valid/ready.

---
 rtl/pe_rs_pkg.sv | 36 +++
 rtl/pe_mac_acc.sv | 55 +++++
 rtl/pe_rs_multi.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_rs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_rs_pkg
// Purpose  : Shared definitions for the row-stationary multi-filter PE.
//            Holds the FSM state encoding, the output-length helper and
//            counter-width helpers.
// Revision : 1.0 - initial release
// ============================================================================
package pe_rs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_W  = 3'd1,
    ST_LOAD_A  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_ACCUM   = 3'd4,
    ST_DRAIN   = 3'd5
  } state_e;

  // Number of valid output positions of a strided 1-D convolution (floor).
  function automatic int out_len(input int act_len, input int kernel,
                                 input int stride);
    return (act_len - kernel) / stride + 1;
  endfunction

  // Bits needed to index 0..n-1; never less than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_mac_acc.sv
`default_nettype none
// ============================================================================
// Module   : pe_mac_acc
// Purpose  : Registered signed multiply-accumulate. sum_o is the
//            combinational result of this step; it is registered into the
//            accumulator when en_i is high. clr_i drops the previous
//            accumulator value so the first tap of a window starts fresh.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            en_i              - advance the accumulator this cycle
//            clr_i             - first tap: ignore the stored accumulator
//            a_i, b_i          - signed DATA_W operands
//            sum_o             - signed ACC_W step result (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module pe_mac_acc #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [ACC_W-1:0]  sum_o
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    base;
  logic signed [ACC_W-1:0]    acc_q;

  assign prod = a_i * b_i;

  generate
    if (ACC_W > 2*DATA_W) begin : g_prod_sext
      assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end else begin : g_prod_same
      assign prod_ext = prod;
    end
  endgenerate

  assign base  = clr_i ? '0 : acc_q;
  assign sum_o = base + prod_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pe_rs_multi.sv
`default_nettype none
// ============================================================================
// Module   : pe_rs_multi
// Purpose  : Row-stationary PE holding NUM_FILT filter rows and one ifmap
//            row. Computes a strided 1-D convolution of each filter against
//            the ifmap row (one MAC per cycle), optionally adds a neighbour
//            psum row, then streams results out over valid/ready.
// Ports    : clk, reset                  - clock, sync active-high reset
//            load_w_i / load_a_i/start_i - command pulses (IDLE only)
//            accum_en_i                  - captured with start_i
//            w_in_*   - weight stream, filter-major then tap order
//            a_in_*   - activation stream, index order
//            psum_in_*  - neighbour psum stream (ACCUM state)
//            psum_out_* - result stream, filter-major then output index
//            busy_o, load_done_o, compute_done_o - status
// Revision : 1.0 - initial release
// ============================================================================
module pe_rs_multi
  import pe_rs_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24,
  parameter int KERNEL   = 3,
  parameter int ACT_LEN  = 5,
  parameter int NUM_FILT = 2,
  parameter int STRIDE   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_w_i,
  input  logic              load_a_i,
  input  logic              start_i,
  input  logic              accum_en_i,
  input  logic              w_in_valid_i,
  output logic              w_in_ready_o,
  input  logic [DATA_W-1:0] w_in_data_i,
  input  logic              a_in_valid_i,
  output logic              a_in_ready_o,
  input  logic [DATA_W-1:0] a_in_data_i,
  input  logic              psum_in_valid_i,
  output logic              psum_in_ready_o,
  input  logic [ACC_W-1:0]  psum_in_data_i,
  output logic              psum_out_valid_o,
  input  logic              psum_out_ready_i,
  output logic [ACC_W-1:0]  psum_out_data_o,
  output logic              busy_o,
  output logic              load_done_o,
  output logic              compute_done_o
);

  localparam int OUT_LEN = out_len(ACT_LEN, KERNEL, STRIDE);
  localparam int NPSUM   = NUM_FILT * OUT_LEN;
  localparam int NW      = NUM_FILT * KERNEL;
  localparam int WI_W    = idx_w(NW);
  localparam int AI_W    = idx_w(ACT_LEN);
  localparam int PI_W    = idx_w(NPSUM);
  localparam int F_W     = idx_w(NUM_FILT);
  localparam int O_W     = idx_w(OUT_LEN);
  localparam int K_W     = idx_w(KERNEL);
  localparam int LD_W    = idx_w(max2(NW, ACT_LEN));

  state_e state_q, state_d;

  logic [LD_W-1:0] ld_cnt_q;
  logic [F_W-1:0]  f_q;
  logic [O_W-1:0]  o_q;
  logic [K_W-1:0]  k_q;
  logic [PI_W-1:0] idx_q;
  logic            accum_q;
  logic            load_done_q;

  logic signed [DATA_W-1:0] wspad_q [NW];
  logic signed [DATA_W-1:0] aspad_q [ACT_LEN];
  logic        [ACC_W-1:0]  pspad_q [NPSUM];

  logic            w_ld_last, a_ld_last;
  logic            k_last, o_last, f_last, cmp_last, idx_last;
  logic [WI_W-1:0] w_ridx;
  logic [AI_W-1:0] a_ridx;
  logic [PI_W-1:0] p_widx;
  logic            mac_en;
  logic            mac_clr;
  logic signed [ACC_W-1:0] mac_sum;

  assign w_ld_last = (ld_cnt_q == LD_W'(NW-1));
  assign a_ld_last = (ld_cnt_q == LD_W'(ACT_LEN-1));
  assign k_last    = (k_q == K_W'(KERNEL-1));
  assign o_last    = (o_q == O_W'(OUT_LEN-1));
  assign f_last    = (f_q == F_W'(NUM_FILT-1));
  assign cmp_last  = k_last && o_last && f_last;
  assign idx_last  = (idx_q == PI_W'(NPSUM-1));

  // Scratchpad addresses for the current compute step.
  assign w_ridx = WI_W'(int'(f_q) * KERNEL + int'(k_q));
  assign a_ridx = AI_W'(int'(o_q) * STRIDE + int'(k_q));
  assign p_widx = PI_W'(int'(f_q) * OUT_LEN + int'(o_q));

  assign mac_en  = (state_q == ST_COMPUTE);
  assign mac_clr = (k_q == '0);

  pe_mac_acc #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .en_i  (mac_en),
    .clr_i (mac_clr),
    .a_i   (wspad_q[w_ridx]),
    .b_i   (aspad_q[a_ridx]),
    .sum_o (mac_sum)
  );

  assign busy_o      = (state_q != ST_IDLE);
  assign load_done_o = load_done_q;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d          = state_q;
    w_in_ready_o     = 1'b0;
    a_in_ready_o     = 1'b0;
    psum_in_ready_o  = 1'b0;
    psum_out_valid_o = 1'b0;
    psum_out_data_o  = '0;
    compute_done_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_w_i) begin
          state_d = ST_LOAD_W;
        end else if (load_a_i) begin
          state_d = ST_LOAD_A;
        end else if (start_i) begin
          state_d = ST_COMPUTE;
        end
      end
      ST_LOAD_W: begin
        w_in_ready_o = 1'b1;
        if (w_in_valid_i && w_ld_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_A: begin
        a_in_ready_o = 1'b1;
        if (a_in_valid_i && a_ld_last) begin
          state_d = ST_IDLE;
        end
      end
      ST_COMPUTE: begin
        if (cmp_last) begin
          state_d = accum_q ? ST_ACCUM : ST_DRAIN;
        end
      end
      ST_ACCUM: begin
        psum_in_ready_o = 1'b1;
        if (psum_in_valid_i && idx_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        psum_out_valid_o = 1'b1;
        psum_out_data_o  = pspad_q[idx_q];
        if (psum_out_ready_i && idx_last) begin
          compute_done_o = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Counters and scratchpads
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_cnt_q    <= '0;
      f_q         <= '0;
      o_q         <= '0;
      k_q         <= '0;
      idx_q       <= '0;
      accum_q     <= 1'b0;
      load_done_q <= 1'b0;
      for (int i = 0; i < NW; i++) begin
        wspad_q[i] <= '0;
      end
      for (int i = 0; i < ACT_LEN; i++) begin
        aspad_q[i] <= '0;
      end
      for (int i = 0; i < NPSUM; i++) begin
        pspad_q[i] <= '0;
      end
    end else begin
      load_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // start only wins when neither load command is present.
          if (!load_w_i && !load_a_i && start_i) begin
            accum_q <= accum_en_i;
          end
        end
        ST_LOAD_W: begin
          if (w_in_valid_i) begin
            wspad_q[WI_W'(ld_cnt_q)] <= w_in_data_i;
            if (w_ld_last) begin
              ld_cnt_q    <= '0;
              load_done_q <= 1'b1;
            end else begin
              ld_cnt_q <= ld_cnt_q + LD_W'(1);
            end
          end
        end
        ST_LOAD_A: begin
          if (a_in_valid_i) begin
            aspad_q[AI_W'(ld_cnt_q)] <= a_in_data_i;
            if (a_ld_last) begin
              ld_cnt_q    <= '0;
              load_done_q <= 1'b1;
            end else begin
              ld_cnt_q <= ld_cnt_q + LD_W'(1);
            end
          end
        end
        ST_COMPUTE: begin
          // The last tap's MAC result is the finished window sum.
          if (k_last) begin
            pspad_q[p_widx] <= mac_sum;
            k_q <= '0;
            if (o_last) begin
              o_q <= '0;
              if (f_last) begin
                f_q <= '0;
              end else begin
                f_q <= f_q + F_W'(1);
              end
            end else begin
              o_q <= o_q + O_W'(1);
            end
          end else begin
            k_q <= k_q + K_W'(1);
          end
        end
        ST_ACCUM: begin
          if (psum_in_valid_i) begin
            pspad_q[idx_q] <= pspad_q[idx_q] + psum_in_data_i;
            idx_q <= idx_last ? '0 : idx_q + PI_W'(1);
          end
        end
        ST_DRAIN: begin
          if (psum_out_ready_i) begin
            idx_q <= idx_last ? '0 : idx_q + PI_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
